// File: rtl/fc_pkg.sv
// Shared definitions for the FC-layer result readout: default sizes, index-width helper, FSM states.
package fc_pkg;

  localparam int unsigned FC_W        = 8;
  localparam int unsigned FC_OUT_SIZE = 10;

  // Index width for n elements, never below one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/fc_output_reader_if.sv
// Valid/ready element stream carrying one signed result element and its index per beat.
interface fc_output_reader_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 4
) ();

  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic [IDX_W-1:0] m_index;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_index,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_index,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fc_argmax_tracker.sv
// Running argmax over a stream of signed elements; first beat always loads, later beats
// replace only on a strictly greater value so ties keep the lowest index.
module fc_argmax_tracker
  import fc_pkg::*;
#(
  parameter int unsigned W     = FC_W,
  parameter int unsigned IDX_W = idx_width(FC_OUT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             beat,
  input  logic [W-1:0]     data,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     best_val,
  output logic [IDX_W-1:0] best_idx
);

  logic [W-1:0]     best_val_q, best_val_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             take_c;

  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    take_c     = (idx == '0) || ($signed(data) > $signed(best_val_q));
    if (clear) begin
      best_val_d = '0;
      best_idx_d = '0;
    end else if (beat && take_c) begin
      best_val_d = data;
      best_idx_d = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_val = best_val_q;
  assign best_idx = best_idx_q;

endmodule

// File: rtl/fc_output_reader.sv
// Captures the FC result vector on an armed producer done, streams it element by element
// and reports the argmax class once the final element has been accepted.
module fc_output_reader
  import fc_pkg::*;
#(
  parameter int unsigned OUT_SIZE = FC_OUT_SIZE,
  parameter int unsigned W        = FC_W,
  parameter int unsigned IDX_W    = idx_width(OUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W*OUT_SIZE-1:0] in_vector_flat,
  fc_output_reader_if.master    m,
  output logic [IDX_W-1:0]      class_idx,
  output logic [W-1:0]          class_val,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

  state_e           state_q, state_d;
  logic             armed_q, armed_d;
  logic [W-1:0]     elem_q [OUT_SIZE];
  logic [W-1:0]     elem_d [OUT_SIZE];
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] cnt_nxt_c;
  logic             m_valid_q, m_valid_d;
  logic [W-1:0]     m_data_q, m_data_d;
  logic [IDX_W-1:0] m_index_q, m_index_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             beat_c;
  logic             clear_c;

  // Next state and registered stream payload; the payload always reflects elem[cnt]
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | ~start;
    elem_d    = elem_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_index_d = m_index_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = done_q;
    clear_c   = 1'b0;
    beat_c    = 1'b0;
    cnt_nxt_c = IDX_W'(cnt_q + IDX_W'(1));

    case (state_q)
      IDLE, DONE: begin
        if (start && armed_q) begin
          state_d   = STREAM;
          armed_d   = 1'b0;
          for (int j = 0; j < OUT_SIZE; j++) begin
            elem_d[j] = in_vector_flat[j*W +: W];
          end
          cnt_d     = '0;
          m_valid_d = 1'b1;
          m_data_d  = in_vector_flat[W-1:0];
          m_index_d = '0;
          m_last_d  = (LAST_IDX == '0);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          clear_c   = 1'b1;
        end
      end

      STREAM: begin
        beat_c = m_valid_q & m.m_ready;
        if (beat_c) begin
          if (m_last_q) begin
            state_d   = DONE;
            m_valid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
          end else begin
            cnt_d     = cnt_nxt_c;
            m_data_d  = elem_q[cnt_nxt_c];
            m_index_d = cnt_nxt_c;
            m_last_d  = (cnt_nxt_c == LAST_IDX);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      for (int j = 0; j < OUT_SIZE; j++) begin
        elem_q[j] <= '0;
      end
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_index_q <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      elem_q    <= elem_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_index_q <= m_index_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Tracker settles on the final best at the same edge done rises, then holds through DONE
  fc_argmax_tracker #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_c),
    .beat     (beat_c),
    .data     (m_data_q),
    .idx      (m_index_q),
    .best_val (class_val),
    .best_idx (class_idx)
  );

  assign m.m_valid = m_valid_q;
  assign m.m_data  = m_data_q;
  assign m.m_index = m_index_q;
  assign m.m_last  = m_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
